// File: rtl/ddr_cmd_pkg.sv
// rtl/ddr_cmd_pkg.sv - shared command codes, bus widths and responder state encoding
//
// Imported by the request-queue block and by ddr_cmd_responder so both sides
// agree on command codes and DDR command-interface widths.
package ddr_cmd_pkg;

  localparam int DDR_ADDR_W = 25;
  localparam int DDR_DATA_W = 128;

  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b0011;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_GAP
  } ddr_state_e;

endpackage

// File: rtl/ddr_cmd_responder_if.sv
// rtl/ddr_cmd_responder_if.sv - DDR command interface between request queue and responder
//
// master: request queue (drives cmd/cmd_valid/ddr_address/ddr_wr_data)
// slave : DDR controller or its on-chip stand-in (drives busy, read return,
//         init_done and the sticky error flag)
interface ddr_cmd_responder_if;
  import ddr_cmd_pkg::*;

  logic [3:0]            cmd;
  logic                  cmd_valid;
  logic [DDR_ADDR_W-1:0] ddr_address;
  logic [DDR_DATA_W-1:0] ddr_wr_data;
  logic                  cmd_busy;
  logic [DDR_DATA_W-1:0] ddr_rd_data;
  logic                  ddr_data_valid;
  logic                  init_done;
  logic                  cmd_err;

  modport master (
    output cmd, cmd_valid, ddr_address, ddr_wr_data,
    input  cmd_busy, ddr_rd_data, ddr_data_valid, init_done, cmd_err
  );

  modport slave (
    input  cmd, cmd_valid, ddr_address, ddr_wr_data,
    output cmd_busy, ddr_rd_data, ddr_data_valid, init_done, cmd_err
  );

endinterface

// File: rtl/ddr_stub_mem.sv
// rtl/ddr_stub_mem.sv - single-port synchronous RAM, registered read, write-first
//
// Ports:
//   clk   - clock
//   en    - access enable (read or write this edge)
//   we    - write enable, qualified by en
//   addr  - word address
//   wdata - write data
//   rdata - registered read data; on a write it returns the written word,
//           and it holds its value while en is low
module ddr_stub_mem #(
  parameter int AW = 10,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata     <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ddr_cmd_responder.sv
// rtl/ddr_cmd_responder.sv - on-chip DDR controller stand-in serving single-word commands
//
// Purpose: responds on the DDR command interface like the real controller
// (init delay, busy window, read-return latency) but services commands from
// an internal block RAM of 2^MEM_AW x 128-bit words.
//
// Ports:
//   clk_133M   - sole clock
//   rst_n_133M - asynchronous active-low reset
//   bus        - DDR command interface, slave side
//                (cmd/cmd_valid/ddr_address/ddr_wr_data in;
//                 cmd_busy/ddr_rd_data/ddr_data_valid/init_done/cmd_err out)
module ddr_cmd_responder
  import ddr_cmd_pkg::*;
#(
  parameter int MEM_AW      = 10,
  parameter int INIT_CYCLES = 200,
  parameter int WR_CYCLES   = 4,
  parameter int RD_LATENCY  = 8
) (
  input  logic               clk_133M,
  input  logic               rst_n_133M,
  ddr_cmd_responder_if.slave bus
);

  localparam int CNT_MAX = (INIT_CYCLES > WR_CYCLES)
                         ? ((INIT_CYCLES > RD_LATENCY) ? INIT_CYCLES : RD_LATENCY)
                         : ((WR_CYCLES > RD_LATENCY) ? WR_CYCLES : RD_LATENCY);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ddr_state_e            state;
  ddr_state_e            state_next;
  logic [CNT_W-1:0]      cnt;
  logic                  cmd_busy;
  logic                  init_done;
  logic                  accept;
  logic                  mem_en;
  logic                  mem_we;
  logic                  rd_return;
  logic                  cmd_known;
  logic [MEM_AW-1:0]     mem_addr;
  logic [DDR_DATA_W-1:0] mem_rdata;
  logic [DDR_DATA_W-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  cmd_err_q;
  logic                  addr_unused;

  // Word index: bits [2:0] select a 16-bit lane inside the 128-bit word and
  // are ignored; bits above the store size are dropped, so the store aliases.
  assign mem_addr    = bus.ddr_address[MEM_AW+2:3];
  assign addr_unused = ^{bus.ddr_address[2:0], bus.ddr_address[DDR_ADDR_W-1:MEM_AW+3]};
  assign cmd_known   = (bus.cmd == CMD_WRITE) || (bus.cmd == CMD_READ);

  always_ff @(posedge clk_133M or negedge rst_n_133M) begin
    if (!rst_n_133M) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:  if (cnt == CNT_W'(INIT_CYCLES - 1)) state_next = ST_IDLE;
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd == CMD_WRITE)     state_next = ST_WRITE;
          else if (bus.cmd == CMD_READ) state_next = ST_READ;
          else                          state_next = ST_GAP;
        end
      end
      ST_WRITE: if (cnt == CNT_W'(WR_CYCLES))  state_next = ST_IDLE;
      ST_READ:  if (cnt == CNT_W'(RD_LATENCY)) state_next = ST_IDLE;
      ST_GAP:   state_next = ST_IDLE;
      default:  state_next = ST_INIT;
    endcase
  end

  // The RAM is accessed on the same edge that samples the command, so its
  // registered output already holds the read word in cycle T+1 and stays
  // put (no further access while busy) until the return is launched.
  always_comb begin
    cmd_busy  = (state != ST_IDLE);
    init_done = (state != ST_INIT);
    accept    = (state == ST_IDLE) && bus.cmd_valid;
    mem_en    = accept && cmd_known;
    mem_we    = accept && (bus.cmd == CMD_WRITE);
    rd_return = (state == ST_READ) && (cnt == CNT_W'(RD_LATENCY - 1));
  end

  // One counter serves INIT, WRITE and READ: it reads k in cycle T+k of a
  // command, and counts edges since reset release while in INIT.
  always_ff @(posedge clk_133M or negedge rst_n_133M) begin
    if (!rst_n_133M) begin
      cnt <= '0;
    end else if (state_next != state) begin
      cnt <= CNT_W'(1);
    end else if (state != ST_IDLE) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_133M or negedge rst_n_133M) begin
    if (!rst_n_133M) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_return;
      if (rd_return) begin
        rd_data_q <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk_133M or negedge rst_n_133M) begin
    if (!rst_n_133M) begin
      cmd_err_q <= 1'b0;
    end else if (bus.cmd_valid && (cmd_busy || !cmd_known)) begin
      cmd_err_q <= 1'b1;
    end
  end

  ddr_stub_mem #(
    .AW (MEM_AW),
    .DW (DDR_DATA_W)
  ) u_mem (
    .clk   (clk_133M),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (bus.ddr_wr_data),
    .rdata (mem_rdata)
  );

  assign bus.cmd_busy       = cmd_busy;
  assign bus.init_done      = init_done;
  assign bus.ddr_data_valid = rd_valid_q;
  assign bus.ddr_rd_data    = rd_data_q;
  assign bus.cmd_err        = cmd_err_q;

endmodule

// File: doc/ddr_cmd_responder.md
# ddr_cmd_responder

Synthesizable on-chip stand-in for the DDR controller, sitting on the responder side of the DDR command interface (cmd/cmd_valid/cmd_busy, ddr_address, ddr_wr_data, ddr_rd_data/ddr_data_valid, init_done). It accepts single-word 128-bit write and read commands from the request queue and services them from a block-RAM store with programmable latency. It mimics the controller's init delay, busy window and read-return timing, so camera-to-VGA bring-up and simulation run without the external memory.

## Interface
- MEM_AW, 10: word-address width of the internal store (2^MEM_AW × 128-bit words)
- INIT_CYCLES, 200: cycles from reset release to init_done
- WR_CYCLES, 4: cycles cmd_busy stays high for a write (≥1)
- RD_LATENCY, 8: cmd_valid-to-ddr_data_valid distance in cycles (≥2)

- clk_133M  in  1  sole clock
- rst_n_133M  in  1  reset, asynchronous, active-low
- cmd  in  4  command code, qualified by cmd_valid
- cmd_valid  in  1  single-cycle command strobe
- ddr_address  in  25  address in 16-bit units
- ddr_wr_data  in  128  write payload
- cmd_busy  out  1  responder cannot accept a command
- ddr_rd_data  out  128  read return data
- ddr_data_valid  out  1  one-cycle qualifier for ddr_rd_data
- init_done  out  1  store ready, sticky until reset
- cmd_err  out  1  sticky protocol-error flag

## Operation
- Reset values: cmd_busy=1, init_done=0, ddr_data_valid=0, ddr_rd_data=0, cmd_err=0. Memory contents are not reset.
- States:
  - INIT: count INIT_CYCLES, then init_done=1 and go to IDLE.
  - IDLE: cmd_busy=0.
    - cmd_valid with cmd=4'b0100: go to WRITE.
    - cmd_valid with cmd=4'b0011: go to READ.
    - Any other code: set cmd_err, go to GAP.
  - WRITE: count WR_CYCLES, then go to IDLE.
  - READ: count to RD_LATENCY, then go to IDLE.
  - GAP: one cycle, then go to IDLE.
- cmd_busy=1 in every state except IDLE.
- Word index = ddr_address[MEM_AW+2:3]. Bits [2:0] are ignored. Bits above MEM_AW+2 are ignored, so the store aliases.
- A write stores ddr_wr_data, captured on the cmd_valid edge, at the word index.
- A read returns the word at the index. A read of a never-written word returns whatever the RAM holds; the bench only checks written words.
- cmd_valid while cmd_busy=1, including during INIT, is dropped: no memory effect, and cmd_err is set.
- cmd_err clears only on reset.

## Timing
- Cycle T = the cycle in which cmd_valid is sampled high in IDLE. cmd_busy goes high in cycle T+1, so the initiator's fetch gating sees it.
- Write:
  - RAM write occurs at the T+1 edge.
  - cmd_busy is high for cycles T+1 … T+WR_CYCLES and low from T+WR_CYCLES+1.
  - A read of the same word issued at T+WR_CYCLES+1 returns the new data.
- Read:
  - RAM read is issued at T+1 (synchronous RAM, 1-cycle access).
  - Data is held in a delay pipeline and ddr_data_valid=1 for exactly cycle T+RD_LATENCY, with ddr_rd_data valid that cycle.
  - ddr_rd_data then holds its value until the next read return.
  - cmd_busy is high for T+1 … T+RD_LATENCY, so ddr_data_valid and cmd_busy overlap in the last cycle.
- Unknown code: cmd_busy is high for T+1 only.
- Minimum command spacing is therefore WR_CYCLES+1 cycles for writes, RD_LATENCY+1 for reads, and 2 for unknown codes.
- Reset asserted mid-operation forces all outputs to reset values immediately (asynchronous). A pending read is discarded and never returns. INIT restarts on release.

## Structure
- Shared package ddr_cmd_pkg holds:
  - CMD_WRITE=4'b0100, CMD_READ=4'b0011
  - DDR_ADDR_W=25, DDR_DATA_W=128
  - The state enumeration
- The request-queue block and this responder both import the package.
- One sub-module, ddr_stub_mem: single-port synchronous RAM, 2^MEM_AW × 128, registered read, write-first. The FSM, counters and read-delay pipeline live in the top.

## Test plan
- Reset release → cmd_busy=1 and init_done=0 through cycle INIT_CYCLES−1; init_done=1 and cmd_busy=0 at cycle INIT_CYCLES. Stays high.
- Write then read-back:
  - Write 128'hDEAD…BEEF at address 25'h000008.
  - After busy drops, read 25'h00000F.
  - Expect ddr_data_valid for exactly one cycle, RD_LATENCY cycles after the read strobe, carrying DEAD…BEEF (low bits ignored).
- Aliasing (MEM_AW=10):
  - Write A to 25'h0 and B to 25'h2000.
  - Read 25'h0 → B.
- Protocol errors:
  - cmd_valid during INIT → cmd_err=1, memory unchanged.
  - cmd=4'b1111 after init → cmd_busy high for exactly 1 cycle, cmd_err=1, no ddr_data_valid.
  - cmd_valid at T+2 of a read → dropped; the original read still returns correct data.
- Reset mid-read:
  - Issue a read, assert rst_n_133M at T+3.
  - Expect no ddr_data_valid ever for that read; outputs at reset values.
  - Previously written data is still readable after the new INIT completes.
- Back-to-back stream: 64 alternating writes and reads issued at minimum spacing → every read matches the model, cmd_err stays 0.
